frame_byte_reader: RTL



---
 rtl/frame_byte_reader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/frame_byte_reader.sv
// Read side of the packed edge-frame RAM: walks addresses 0..FRAME_BYTES-1 on a
// frame-ready pulse and streams each stored byte to the UART over valid/ready.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; address parked at 0
//   HDR   | sync header byte presented, waiting for tx_ready
//   READ  | re asserted for one cycle at the current address
//   LOAD  | RAM data arrives this cycle; captured into tx_data at the edge
//   SEND  | data byte presented, held stable until tx_ready
//   DONE  | one-cycle done pulse, busy already low, address back at 0
module frame_byte_reader #(
  parameter int         FRAME_BYTES = 5280,
  parameter int         ADDR_W      = $clog2(FRAME_BYTES),
  parameter bit         SEND_HEADER = 1'b1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [7:0]        rData,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    READ,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              re_q, re_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              handshake;

  assign handshake = tx_valid_q && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      re_q       <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are computed for the state being entered, so every output is a
  // flop and the header appears one edge after start.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    re_d       = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (SEND_HEADER) begin
            state_d    = HDR;
            tx_data_d  = HEADER_BYTE;
            tx_valid_d = 1'b1;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
          end
        end
      end

      HDR: begin
        if (handshake) begin
          tx_valid_d = 1'b0;
          state_d    = READ;
          re_d       = 1'b1;
        end
      end

      READ: begin
        state_d = LOAD;
      end

      LOAD: begin
        tx_data_d  = rData;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (handshake) begin
          tx_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = READ;
            re_d    = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        addr_d     = '0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign re       = re_q;
  assign rAddr    = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
